// File: rtl/tlp_type_tracker_pkg.sv
// Shared definitions for the TLP type tracker: class table, Fmt/Type bytes,
// counter slots and FSM state encoding.
package tlp_pkg;

   localparam int unsigned NUM_CLASS   = 10;
   localparam int unsigned CNT_UNKNOWN = NUM_CLASS;
   localparam int unsigned CNT_PERR    = NUM_CLASS + 1;
   localparam int unsigned NUM_CNT     = NUM_CLASS + 2;

   localparam int unsigned CLS_MRD    = 0;
   localparam int unsigned CLS_MRDLK  = 1;
   localparam int unsigned CLS_IORD   = 2;
   localparam int unsigned CLS_IOWR   = 3;
   localparam int unsigned CLS_CFGRD0 = 4;
   localparam int unsigned CLS_CFGWR0 = 5;
   localparam int unsigned CLS_CFGRD1 = 6;
   localparam int unsigned CLS_CFGWR1 = 7;
   localparam int unsigned CLS_CPL    = 8;
   localparam int unsigned CLS_CPLD   = 9;

   localparam logic [7:0] FT_MRD    = 8'h00;
   localparam logic [7:0] FT_MRDLK  = 8'h01;
   localparam logic [7:0] FT_IORD   = 8'h02;
   localparam logic [7:0] FT_IOWR   = 8'h42;
   localparam logic [7:0] FT_CFGRD0 = 8'h04;
   localparam logic [7:0] FT_CFGWR0 = 8'h44;
   localparam logic [7:0] FT_CFGRD1 = 8'h05;
   localparam logic [7:0] FT_CFGWR1 = 8'h45;
   localparam logic [7:0] FT_CPL    = 8'h0A;
   localparam logic [7:0] FT_CPLD   = 8'h4A;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_t;

endpackage

// File: rtl/tlp_type_tracker_if.sv
// Byte-stream input and decoded-result handshake of the TLP type tracker.
interface tlp_type_tracker_if #(
   parameter int unsigned NUM_CLASS = tlp_pkg::NUM_CLASS
);
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_sop;
   logic                 in_eop;
   logic                 in_ready;
   logic [NUM_CLASS-1:0] cls_onehot;
   logic                 cls_unknown;
   logic                 cls_valid;
   logic                 cls_ready;

   modport master (
      output in_data, in_valid, in_sop, in_eop, cls_ready,
      input  in_ready, cls_onehot, cls_unknown, cls_valid
   );

   modport slave (
      input  in_data, in_valid, in_sop, in_eop, cls_ready,
      output in_ready, cls_onehot, cls_unknown, cls_valid
   );
endinterface

// File: rtl/tlp_type_tracker_decode.sv
// Combinational Fmt/Type header decode into a one-hot class plus unknown flag.
module tlp_type_decode
   import tlp_pkg::*;
(
   input  logic [7:0]           i_hdr,
   output logic [NUM_CLASS-1:0] o_onehot,
   output logic                 o_unknown
);

   always_comb begin
      o_onehot  = '0;
      o_unknown = 1'b0;
      case (i_hdr)
         FT_MRD:    o_onehot[CLS_MRD]    = 1'b1;
         FT_MRDLK:  o_onehot[CLS_MRDLK]  = 1'b1;
         FT_IORD:   o_onehot[CLS_IORD]   = 1'b1;
         FT_IOWR:   o_onehot[CLS_IOWR]   = 1'b1;
         FT_CFGRD0: o_onehot[CLS_CFGRD0] = 1'b1;
         FT_CFGWR0: o_onehot[CLS_CFGWR0] = 1'b1;
         FT_CFGRD1: o_onehot[CLS_CFGRD1] = 1'b1;
         FT_CFGWR1: o_onehot[CLS_CFGWR1] = 1'b1;
         FT_CPL:    o_onehot[CLS_CPL]    = 1'b1;
         FT_CPLD:   o_onehot[CLS_CPLD]   = 1'b1;
         default:   o_unknown            = 1'b1;
      endcase
   end

endmodule

// File: rtl/tlp_type_tracker.sv
// TLP type tracker: frames the byte stream, decodes each header into a
// single-entry result register and keeps saturating per-class counters.
module tlp_type_tracker
   import tlp_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned NUM_CLASS = tlp_pkg::NUM_CLASS
) (
   input  logic                 clk,
   input  logic                 rst,
   tlp_type_tracker_if.slave    bus,
   input  logic [3:0]           rd_sel,
   output logic [CNT_W-1:0]     rd_cnt,
   input  logic                 clr_cnt,
   output logic                 proto_err
);

   localparam int unsigned   N_CNT   = NUM_CLASS + 2;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_nstate;
   logic                 r_cls_valid;
   logic [NUM_CLASS-1:0] r_onehot;
   logic                 r_unknown;
   logic                 r_proto_err;
   logic [CNT_W-1:0]     r_cnt [N_CNT];

   logic [NUM_CLASS-1:0] w_onehot;
   logic                 w_unknown;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_hdr;
   logic                 w_err;
   logic [N_CNT-1:0]     w_inc;

   tlp_type_decode u_decode (
      .i_hdr     (bus.in_data),
      .o_onehot  (w_onehot),
      .o_unknown (w_unknown)
   );

   always_comb begin
      w_ready  = !r_cls_valid || bus.cls_ready;
      w_accept = bus.in_valid && w_ready;
      w_hdr    = w_accept && bus.in_sop;
      // Framing error: sop inside a packet, or a non-sop beat outside one.
      w_err    = w_accept && (bus.in_sop == (r_state == ST_BODY));

      w_nstate = r_state;
      if (w_hdr)
         w_nstate = bus.in_eop ? ST_IDLE : ST_BODY;
      else if (w_accept && bus.in_eop)
         w_nstate = ST_IDLE;

      w_inc = '0;
      if (w_hdr) begin
         w_inc[NUM_CLASS-1:0] = w_onehot;
         w_inc[CNT_UNKNOWN]   = w_unknown;
      end
      w_inc[CNT_PERR] = w_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cls_valid <= 1'b0;
         r_onehot    <= '0;
         r_unknown   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_nstate;
         r_proto_err <= w_err;
         if (w_hdr) begin
            r_cls_valid <= 1'b1;
            r_onehot    <= w_onehot;
            r_unknown   <= w_unknown;
         end else if (bus.cls_ready) begin
            r_cls_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < N_CNT; k++)
            r_cnt[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < N_CNT; k++) begin
            if (clr_cnt)
               r_cnt[k] <= '0;
            else if (w_inc[k] && (r_cnt[k] != '1))
               r_cnt[k] <= r_cnt[k] + CNT_ONE;
         end
      end
   end

   always_comb begin
      rd_cnt = '0;
      for (int unsigned k = 0; k < N_CNT; k++)
         if (rd_sel == 4'(k))
            rd_cnt = r_cnt[k];
   end

   assign bus.in_ready    = w_ready;
   assign bus.cls_valid   = r_cls_valid;
   assign bus.cls_onehot  = r_onehot;
   assign bus.cls_unknown = r_unknown;
   assign proto_err       = r_proto_err;

endmodule

// File: tb/tb_tlp_type_tracker.sv
// Directed bench for tlp_type_tracker with a packet-level reference model
// checked every cycle; a CNT_W=4 copy shares the stimulus for saturation.
module tb_tlp_type_tracker;
   import tlp_pkg::*;

   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic [3:0]  rd_sel  = '0;
   logic        clr_cnt = 1'b0;
   logic [15:0] rd_cnt;
   logic [3:0]  rd_cnt4;
   logic        perr;
   logic        perr4;

   int n_vec = 0;
   int n_err = 0;

   tlp_type_tracker_if #(.NUM_CLASS(NUM_CLASS)) bus ();
   tlp_type_tracker_if #(.NUM_CLASS(NUM_CLASS)) bus4 ();

   assign bus4.in_data   = bus.in_data;
   assign bus4.in_valid  = bus.in_valid;
   assign bus4.in_sop    = bus.in_sop;
   assign bus4.in_eop    = bus.in_eop;
   assign bus4.cls_ready = bus.cls_ready;

   always #5 clk = ~clk;

   tlp_type_tracker #(.CNT_W(16), .NUM_CLASS(NUM_CLASS)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .rd_sel    (rd_sel),
      .rd_cnt    (rd_cnt),
      .clr_cnt   (clr_cnt),
      .proto_err (perr)
   );

   tlp_type_tracker #(.CNT_W(4), .NUM_CLASS(NUM_CLASS)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus4),
      .rd_sel    (rd_sel),
      .rd_cnt    (rd_cnt4),
      .clr_cnt   (clr_cnt),
      .proto_err (perr4)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: packet framing and counting from the class table.
   logic [7:0] hdr_tbl [10] = '{8'h00, 8'h01, 8'h02, 8'h42, 8'h04,
                                8'h44, 8'h05, 8'h45, 8'h0A, 8'h4A};
   int         cnt [12];
   bit         m_pkt, m_valid, m_unk, m_err;
   logic [9:0] m_oh;
   bit         cmp_en = 1'b0;

   function automatic int class_of(input logic [7:0] b);
      for (int i = 0; i < 10; i++)
         if (hdr_tbl[i] == b) return i;
      return -1;
   endfunction

   function automatic int exp_cnt(input int s, input int mx);
      if (s > 11) return 0;
      return (cnt[s] > mx) ? mx : cnt[s];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pkt = 0; m_valid = 0; m_unk = 0; m_err = 0; m_oh = '0;
         foreach (cnt[i]) cnt[i] = 0;
      end else begin
         bit rdy, acc, err;
         int c;
         rdy = !m_valid || bus.cls_ready;
         acc = bus.in_valid && rdy;
         err = 0;
         if (acc && bus.in_sop) begin
            err     = m_pkt;
            c       = class_of(bus.in_data);
            m_valid = 1;
            m_unk   = (c < 0);
            m_oh    = (c < 0) ? 10'd0 : (10'd1 << c);
            cnt[(c < 0) ? 10 : c]++;
            m_pkt   = !bus.in_eop;
         end else begin
            if (m_valid && bus.cls_ready) m_valid = 0;
            if (acc) begin
               if (!m_pkt) err = 1;
               else if (bus.in_eop) m_pkt = 0;
            end
         end
         if (err) cnt[11]++;
         if (clr_cnt) foreach (cnt[i]) cnt[i] = 0;
         m_err = err;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready",    bus.in_ready,    !m_valid || bus.cls_ready);
         chk("cls_valid",   bus.cls_valid,   m_valid);
         chk("cls_onehot",  bus.cls_onehot,  m_oh);
         chk("cls_unknown", bus.cls_unknown, m_unk);
         chk("proto_err",   perr,            m_err);
         chk("rd_cnt",      rd_cnt,          exp_cnt(int'(rd_sel), 65535));
         chk("rd_cnt4",     rd_cnt4,         exp_cnt(int'(rd_sel), 15));
         chk("cls_valid4",  bus4.cls_valid,  m_valid);
      end
   end

   task automatic send(input logic [7:0] d, input logic s, input logic e);
      bit rdy, done;
      done = 0;
      bus.in_data = d; bus.in_sop = s; bus.in_eop = e; bus.in_valid = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         done = rdy;
      end
      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic rd_chk(input int sel, input int exp);
      rd_sel = 4'(sel);
      #1;
      chk($sformatf("cnt16[%0d]", sel), rd_cnt, exp);
      chk($sformatf("cnt4[%0d]", sel), rd_cnt4, (exp > 15) ? 15 : exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data = '0; bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0;
      bus.cls_ready = 1'b1;
      #1 rst = 1'b1;
      @(posedge clk); #1 cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_valid", bus.cls_valid, 0);
      chk("rst_ready", bus.in_ready, 1);
      for (int k = 0; k < 12; k++) rd_chk(k, 0);

      // One packet per class, header then two body beats.
      for (int i = 0; i < 10; i++) begin
         if (i == 4) chk("pre_valid_04", bus.cls_valid, 0);
         send(hdr_tbl[i], 1'b1, 1'b0);
         if (i == 4) begin
            chk("lat_valid_04", bus.cls_valid, 1);
            chk("onehot_04", bus.cls_onehot, 10'h010);
         end
         send(8'hAB, 1'b0, 1'b0);
         send(8'hCD, 1'b0, 1'b1);
      end
      for (int k = 0; k < 10; k++) rd_chk(k, 1);
      rd_chk(10, 0);

      send(8'h7F, 1'b1, 1'b1);
      chk("unk_flag", bus.cls_unknown, 1);
      chk("unk_onehot", bus.cls_onehot, 10'h000);
      rd_chk(10, 1);
      @(posedge clk); #1;

      // Backpressure: second header must wait for the first result.
      bus.cls_ready = 1'b0;
      send(8'h0A, 1'b1, 1'b1);
      chk("bp_ready_low", bus.in_ready, 0);
      chk("bp_onehot_a", bus.cls_onehot, 10'h100);
      fork
         send(8'h4A, 1'b1, 1'b1);
         begin
            repeat (3) @(negedge clk);
            chk("bp_hold_onehot", bus.cls_onehot, 10'h100);
            chk("bp_hold_ready", bus.in_ready, 0);
            chk("bp_hold_valid", bus.cls_valid, 1);
            @(posedge clk);
            #2 bus.cls_ready = 1'b1;
         end
      join
      chk("bp_onehot_b", bus.cls_onehot, 10'h200);
      rd_chk(8, 2);
      rd_chk(9, 2);
      @(posedge clk); #1;

      // sop inside a packet, then a stray body beat outside one.
      send(8'h00, 1'b1, 1'b0);
      send(8'h42, 1'b1, 1'b1);
      chk("perr_sop_in_body", perr, 1);
      chk("perr_redecode", bus.cls_onehot, 10'h008);
      send(8'h11, 1'b0, 1'b0);
      chk("perr_stray", perr, 1);
      rd_chk(11, 2);
      rd_chk(0, 2);
      rd_chk(3, 2);
      @(posedge clk); #1;
      chk("perr_pulse_end", perr, 0);

      // Saturation on the 4-bit copy and clear-vs-increment priority.
      clr_cnt = 1'b1;
      @(posedge clk); #1 clr_cnt = 1'b0;
      rd_chk(9, 0);
      for (int i = 0; i < 17; i++) send(8'h4A, 1'b1, 1'b1);
      rd_sel = 4'd9; #1;
      chk("sat_cnt4", rd_cnt4, 15);
      chk("sat_cnt16", rd_cnt, 17);
      clr_cnt = 1'b1;
      send(8'h4A, 1'b1, 1'b1);
      clr_cnt = 1'b0;
      rd_chk(9, 0);

      // Reset in the middle of a packet.
      send(8'h00, 1'b1, 1'b0);
      send(8'hAB, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.cls_valid, 0);
      chk("mid_rst_onehot", bus.cls_onehot, 10'h000);
      chk("mid_rst_unknown", bus.cls_unknown, 0);
      chk("mid_rst_perr", perr, 0);
      chk("mid_rst_ready", bus.in_ready, 1);
      chk("mid_rst_cnt", rd_cnt, 0);
      @(posedge clk); #1 rst = 1'b0;
      send(8'h44, 1'b1, 1'b0);
      chk("post_rst_onehot", bus.cls_onehot, 10'h020);
      chk("post_rst_valid", bus.cls_valid, 1);
      send(8'hCD, 1'b0, 1'b1);
      chk("post_rst_perr", perr, 0);
      rd_chk(5, 1);
      rd_chk(11, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tlp_type_tracker.md
TLP_TYPE_TRACKER -- requirements
Module: tlp_type_tracker

Interface
REQ-001 Parameter CNT_W, default 16, sets per-class counter width (range 4..32).
REQ-002 Parameter NUM_CLASS, default 10, sets the number of decoded classes; fixed by the package class table.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  TLP byte stream; the first byte of a packet is Fmt/Type.
REQ-006 in_valid  input  1  in_data, in_sop and in_eop are valid.
REQ-007 in_sop / in_eop  input  1 each  start- and end-of-packet markers; both may be set on the same beat (one-byte packet).
REQ-008 in_ready  output  1  tracker accepts the beat; transfer occurs when in_valid and in_ready are both 1.
REQ-009 cls_onehot  output  NUM_CLASS  decoded class of the last accepted header.
REQ-010 cls_unknown  output  1  header byte matched no class.
REQ-011 cls_valid / cls_ready  output / input  1 each  result handshake.
REQ-012 rd_sel  input  4  selects a counter: 0..9 = class counters, 10 = unknown counter, 11 = protocol-error counter, other values read as 0.
REQ-013 rd_cnt  output  CNT_W  combinational read of the counter selected by rd_sel.
REQ-014 clr_cnt  input  1  synchronous clear of all counters.
REQ-015 proto_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-016 Class map: 00 MRd 0, 01 MRdLk 1, 02 IORd 2, 42 IOWr 3, 04 CfgRd0 4, 44 CfgWr0 5, 05 CfgRd1 6, 45 CfgWr1 7, 0A Cpl 8, 4A CplD 9; every other byte value is unknown.
REQ-017 FSM states: IDLE (awaiting in_sop) and BODY (inside a packet).
REQ-018 IDLE with an accepted sop beat: decode in_data, load the result register, and go to BODY; if eop is also set, remain in IDLE.
REQ-019 BODY: accepted beats are ignored for decode; an accepted eop beat returns the FSM to IDLE.
REQ-020 An accepted sop beat while in BODY shall pulse proto_err, increment the error counter, and be treated as a new header (decode applies).
REQ-021 An accepted non-sop beat in IDLE shall pulse proto_err, increment the error counter, and be dropped; the FSM stays in IDLE.
REQ-022 Result latency: cls_valid rises exactly one cycle after the accepted sop beat.
REQ-023 Result register: single entry; cls_valid stays high and cls_onehot / cls_unknown stay stable until cls_valid and cls_ready are both 1.
REQ-024 Backpressure: in_ready = !cls_valid || cls_ready, in all states.
REQ-025 For an unknown header, cls_onehot = 0 and cls_unknown = 1; otherwise exactly one cls_onehot bit is set.
REQ-026 Counters increment on the header-accept cycle, not on result consumption.
REQ-027 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr_cnt has priority over a same-cycle increment; the counter reads 0 on the following cycle.
REQ-029 Outputs are registered except in_ready and rd_cnt.

Reset
REQ-030 On rst: FSM to IDLE, cls_valid = 0, cls_onehot = 0, cls_unknown = 0, proto_err = 0, all counters = 0.
REQ-031 Reset mid-packet discards the packet; the first post-reset beat must carry sop, otherwise REQ-021 applies.
REQ-032 in_ready = 1 while in reset and after reset.

Structure
REQ-033 Shared package tlp_pkg holds: the class index constants, NUM_CLASS, the Fmt/Type byte constants, and the FSM state enum.
REQ-034 The header decode is a combinational sub-module, tlp_type_decode (8-bit in, NUM_CLASS one-hot out, plus unknown flag), instantiated once.
REQ-035 The counter bank is generated in-line; no further sub-modules.

Verification
REQ-036 Ten single-packet TLPs, one per class (sop = 04, body, eop), with cls_ready = 1 -> cls_onehot = 10'h010 for 04, cls_valid one cycle after sop, and each class counter = 1.
REQ-037 Header 0x7F -> cls_unknown = 1, cls_onehot = 0, rd_sel = 10 reads 1.
REQ-038 cls_ready = 0 with two back-to-back packets -> in_ready drops after the first header and the first result holds; after cls_ready = 1 the second is accepted and no header is lost.
REQ-039 sop in BODY, then a non-sop beat in IDLE -> two proto_err pulses, rd_sel = 11 reads 2, and the second sop is decoded.
REQ-040 CNT_W = 4, seventeen CplD packets -> counter 9 reads 15; clr_cnt issued in the same cycle as a CplD header -> reads 0.
REQ-041 rst asserted mid-packet -> all outputs return to their reset values immediately; the next packet decodes correctly.
